// File: rtl/hit_judge_if.sv
// Bundle between the bomb stage / player trackers and hit_judge: explosion map,
// player coordinates, and the resulting lives, hit and round-status outputs.
interface hit_judge_if;
    logic         start;
    logic [255:0] explode;
    logic [7:0]   p1_cor;
    logic [7:0]   p2_cor;
    logic [1:0]   p1_lives;
    logic [1:0]   p2_lives;
    logic         p1_invuln;
    logic         p2_invuln;
    logic         p1_hit;
    logic         p2_hit;
    logic         active;
    logic [1:0]   game_status;

    modport master (
        output start, explode, p1_cor, p2_cor,
        input  p1_lives, p2_lives, p1_invuln, p2_invuln,
        input  p1_hit, p2_hit, active, game_status
    );

    modport slave (
        input  start, explode, p1_cor, p2_cor,
        output p1_lives, p2_lives, p1_invuln, p2_invuln,
        output p1_hit, p2_hit, active, game_status
    );
endinterface

// File: rtl/hit_judge.sv
// Blast hit detection, lives and invulnerability tracking, and the round FSM
// (IDLE -> PLAY -> DYING -> OVER) that produces the final game status.
module hit_judge #(
    parameter int LIVES      = 3,
    parameter int INVULN_CYC = 45,
    parameter int DEATH_CYC  = 18
) (
    input  logic        clk,
    input  logic        reset,
    hit_judge_if.slave  bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PLAY  = 2'd1;
    localparam logic [1:0] ST_DYING = 2'd2;
    localparam logic [1:0] ST_OVER  = 2'd3;

    localparam logic [1:0] GS_NOT_OVER = 2'd0;
    localparam logic [1:0] GS_DRAW     = 2'd1;
    localparam logic [1:0] GS_P1_WIN   = 2'd2;
    localparam logic [1:0] GS_P2_WIN   = 2'd3;

    localparam logic [1:0] LIVES_INIT = 2'(LIVES);
    localparam logic [5:0] INV_LOAD   = 6'(INVULN_CYC);
    localparam logic [5:0] DEATH_LOAD = 6'(DEATH_CYC);

    logic [1:0] state_q, state_d;
    logic [1:0] p1_lives_q, p1_lives_d;
    logic [1:0] p2_lives_q, p2_lives_d;
    logic [5:0] p1_inv_q, p1_inv_d;
    logic [5:0] p2_inv_q, p2_inv_d;
    logic [5:0] death_ctr_q, death_ctr_d;
    logic       p1_hit_q, p1_hit_d;
    logic       p2_hit_q, p2_hit_d;
    logic       p1_invuln_q, p1_invuln_d;
    logic       p2_invuln_q, p2_invuln_d;
    logic       active_q, active_d;
    logic [1:0] game_status_q, game_status_d;

    logic       p1_exp;
    logic       p2_exp;
    logic       judging;
    logic       p1_strike;
    logic       p2_strike;

    assign p1_exp = bus.explode[bus.p1_cor];
    assign p2_exp = bus.explode[bus.p2_cor];

    // The last DYING cycle (counter reading 1) only latches the result; no hits are sampled.
    assign judging   = (state_q == ST_PLAY) ||
                       ((state_q == ST_DYING) && (death_ctr_q > 6'd1));
    assign p1_strike = judging && p1_exp && (p1_inv_q == '0) && (p1_lives_q != '0);
    assign p2_strike = judging && p2_exp && (p2_inv_q == '0) && (p2_lives_q != '0);

    always_comb begin
        state_d       = state_q;
        p1_lives_d    = p1_lives_q;
        p2_lives_d    = p2_lives_q;
        p1_inv_d      = p1_inv_q;
        p2_inv_d      = p2_inv_q;
        death_ctr_d   = death_ctr_q;
        game_status_d = game_status_q;
        p1_hit_d      = 1'b0;
        p2_hit_d      = 1'b0;

        if (judging) begin
            if (p1_strike) begin
                p1_lives_d = p1_lives_q - 2'd1;
                p1_inv_d   = INV_LOAD;
                p1_hit_d   = 1'b1;
            end else if (p1_inv_q != '0) begin
                p1_inv_d = p1_inv_q - 6'd1;
            end

            if (p2_strike) begin
                p2_lives_d = p2_lives_q - 2'd1;
                p2_inv_d   = INV_LOAD;
                p2_hit_d   = 1'b1;
            end else if (p2_inv_q != '0) begin
                p2_inv_d = p2_inv_q - 6'd1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                p1_lives_d    = LIVES_INIT;
                p2_lives_d    = LIVES_INIT;
                p1_inv_d      = '0;
                p2_inv_d      = '0;
                game_status_d = GS_NOT_OVER;
                if (bus.start) begin
                    state_d = ST_PLAY;
                end
            end

            ST_PLAY: begin
                if ((p1_lives_d == '0) || (p2_lives_d == '0)) begin
                    state_d     = ST_DYING;
                    death_ctr_d = DEATH_LOAD;
                end
            end

            ST_DYING: begin
                if (death_ctr_q <= 6'd1) begin
                    state_d     = ST_OVER;
                    death_ctr_d = '0;
                    p1_inv_d    = '0;
                    p2_inv_d    = '0;
                    if ((p1_lives_q == '0) && (p2_lives_q == '0)) begin
                        game_status_d = GS_DRAW;
                    end else if (p2_lives_q == '0) begin
                        game_status_d = GS_P1_WIN;
                    end else begin
                        game_status_d = GS_P2_WIN;
                    end
                end else begin
                    death_ctr_d = death_ctr_q - 6'd1;
                end
            end

            default: begin
                p1_inv_d = '0;
                p2_inv_d = '0;
                if (bus.start) begin
                    state_d       = ST_PLAY;
                    p1_lives_d    = LIVES_INIT;
                    p2_lives_d    = LIVES_INIT;
                    game_status_d = GS_NOT_OVER;
                end
            end
        endcase

        active_d    = (state_d == ST_PLAY) || (state_d == ST_DYING);
        p1_invuln_d = (p1_inv_d != '0);
        p2_invuln_d = (p2_inv_d != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            p1_lives_q    <= LIVES_INIT;
            p2_lives_q    <= LIVES_INIT;
            p1_inv_q      <= '0;
            p2_inv_q      <= '0;
            death_ctr_q   <= '0;
            p1_hit_q      <= 1'b0;
            p2_hit_q      <= 1'b0;
            p1_invuln_q   <= 1'b0;
            p2_invuln_q   <= 1'b0;
            active_q      <= 1'b0;
            game_status_q <= GS_NOT_OVER;
        end else begin
            state_q       <= state_d;
            p1_lives_q    <= p1_lives_d;
            p2_lives_q    <= p2_lives_d;
            p1_inv_q      <= p1_inv_d;
            p2_inv_q      <= p2_inv_d;
            death_ctr_q   <= death_ctr_d;
            p1_hit_q      <= p1_hit_d;
            p2_hit_q      <= p2_hit_d;
            p1_invuln_q   <= p1_invuln_d;
            p2_invuln_q   <= p2_invuln_d;
            active_q      <= active_d;
            game_status_q <= game_status_d;
        end
    end

    assign bus.p1_lives    = p1_lives_q;
    assign bus.p2_lives    = p2_lives_q;
    assign bus.p1_invuln   = p1_invuln_q;
    assign bus.p2_invuln   = p2_invuln_q;
    assign bus.p1_hit      = p1_hit_q;
    assign bus.p2_hit      = p2_hit_q;
    assign bus.active      = active_q;
    assign bus.game_status = game_status_q;

endmodule

// File: tb/tb_hit_judge.sv
// Directed bench for hit_judge: expected output snapshots are queued as stimulus
// is driven and checked once the clock edge has produced the DUT response.
module tb_hit_judge;

    logic clk;
    logic reset;

    hit_judge_if bus ();

    hit_judge #(
        .LIVES      (3),
        .INVULN_CYC (45),
        .DEATH_CYC  (18)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;
    string      exp_name[$];
    logic [10:0] exp_val[$];

    // Snapshot order: p1_lives, p2_lives, p1_invuln, p2_invuln, p1_hit, p2_hit, active, game_status
    function automatic logic [10:0] exp_o(input int l1, input int l2, input int i1, input int i2,
                                          input int h1, input int h2, input int act, input int gs);
        return {2'(l1), 2'(l2), 1'(i1), 1'(i2), 1'(h1), 1'(h2), 1'(act), 2'(gs)};
    endfunction

    function automatic logic [10:0] observed();
        return {bus.p1_lives, bus.p2_lives, bus.p1_invuln, bus.p2_invuln,
                bus.p1_hit, bus.p2_hit, bus.active, bus.game_status};
    endfunction

    task automatic expect_out(input string name, input logic [10:0] v);
        exp_name.push_back(name);
        exp_val.push_back(v);
    endtask

    task automatic check_now();
        string       n;
        logic [10:0] e;
        logic [10:0] got;
        while (exp_val.size() > 0) begin
            n   = exp_name.pop_front();
            e   = exp_val.pop_front();
            got = observed();
            total++;
            assert (got === e) else begin
                bad++;
                $error("FAIL %s observed=%b expected=%b", n, got, e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_check();
        tick();
        check_now();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic blast(input logic [7:0] a, input logic [7:0] b, input logic use_b);
        bus.explode    = '0;
        bus.explode[a] = 1'b1;
        if (use_b) bus.explode[b] = 1'b1;
    endtask

    task automatic start_round();
        bus.start = 1'b1;
        expect_out("start_round", exp_o(3, 3, 0, 0, 0, 0, 1, 0));
        tick_check();
        bus.start = 1'b0;
    endtask

    // Takes both players from 3 lives to 1 with invulnerability fully expired.
    task automatic bring_both_to_one();
        blast(8'h22, 8'h50, 1'b1);
        expect_out("both_hit_a", exp_o(2, 2, 1, 1, 1, 1, 1, 0));
        tick_check();
        bus.explode = '0;
        run(45);
        blast(8'h22, 8'h50, 1'b1);
        expect_out("both_hit_b", exp_o(1, 1, 1, 1, 1, 1, 1, 0));
        tick_check();
        bus.explode = '0;
        run(45);
        expect_out("both_one_life", exp_o(1, 1, 0, 0, 0, 0, 1, 0));
        check_now();
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.explode = '0;
        bus.p1_cor  = 8'h22;
        bus.p2_cor  = 8'h50;

        run(2);
        expect_out("reset_state", exp_o(3, 3, 0, 0, 0, 0, 0, 0));
        check_now();
        reset = 1'b0;
        expect_out("idle_hold", exp_o(3, 3, 0, 0, 0, 0, 0, 0));
        tick_check();

        // Single hit on p1 and the invulnerability window length
        start_round();
        blast(8'h22, 8'h00, 1'b0);
        expect_out("p1_single_hit", exp_o(2, 3, 1, 0, 1, 0, 1, 0));
        tick_check();
        bus.explode = '0;
        expect_out("p1_hit_pulse_end", exp_o(2, 3, 1, 0, 0, 0, 1, 0));
        tick_check();
        run(42);
        expect_out("p1_invuln_last", exp_o(2, 3, 1, 0, 0, 0, 1, 0));
        tick_check();
        expect_out("p1_invuln_clear", exp_o(2, 3, 0, 0, 0, 0, 1, 0));
        tick_check();

        // Continuous explosion on p1 from full lives: hits at 0, 46, 92
        reset = 1'b1;
        #1;
        reset = 1'b0;
        start_round();
        blast(8'h22, 8'h00, 1'b0);
        for (int i = 0; i < 100; i++) begin
            expect_out($sformatf("hold_%0d", i),
                       exp_o(2 - i / 46, 3, (i % 46 != 45) ? 1 : 0, 0,
                             (i % 46 == 0) ? 1 : 0, 0, 1, 0));
            tick_check();
        end
        bus.explode = '0;
        run(9);
        expect_out("p2win_last_dying", exp_o(0, 3, 1, 0, 0, 0, 1, 0));
        tick_check();
        expect_out("p2win_over", exp_o(0, 3, 0, 0, 0, 0, 0, 3));
        tick_check();
        blast(8'h50, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            expect_out($sformatf("over_frozen_%0d", i), exp_o(0, 3, 0, 0, 0, 0, 0, 3));
            tick_check();
        end
        bus.explode = '0;

        // p1 dies, p2 loses last life 10 cycles later -> draw
        start_round();
        bring_both_to_one();
        blast(8'h22, 8'h00, 1'b0);
        expect_out("draw_p1_dies", exp_o(0, 1, 1, 0, 1, 0, 1, 0));
        tick_check();
        bus.explode = '0;
        run(9);
        blast(8'h50, 8'h00, 1'b0);
        expect_out("draw_p2_dies", exp_o(0, 0, 1, 1, 0, 1, 1, 0));
        tick_check();
        bus.explode = '0;
        run(6);
        expect_out("draw_last_dying", exp_o(0, 0, 1, 1, 0, 0, 1, 0));
        tick_check();
        expect_out("draw_over", exp_o(0, 0, 0, 0, 0, 0, 0, 1));
        tick_check();

        // Same, but the p2 blast arrives on the closing edge -> ignored, p2 wins
        start_round();
        bring_both_to_one();
        blast(8'h22, 8'h00, 1'b0);
        expect_out("late_p1_dies", exp_o(0, 1, 1, 0, 1, 0, 1, 0));
        tick_check();
        bus.explode = '0;
        run(16);
        expect_out("late_last_dying", exp_o(0, 1, 1, 0, 0, 0, 1, 0));
        tick_check();
        blast(8'h50, 8'h00, 1'b0);
        expect_out("late_over", exp_o(0, 1, 0, 0, 0, 0, 0, 3));
        tick_check();
        bus.explode = '0;

        // Both players on tile 0x80 with one life each
        start_round();
        bring_both_to_one();
        bus.p1_cor = 8'h80;
        bus.p2_cor = 8'h80;
        blast(8'h80, 8'h00, 1'b0);
        expect_out("shared_tile_hit", exp_o(0, 0, 1, 1, 1, 1, 1, 0));
        tick_check();
        bus.explode = '0;
        run(16);
        expect_out("shared_last_dying", exp_o(0, 0, 1, 1, 0, 0, 1, 0));
        tick_check();
        expect_out("shared_over", exp_o(0, 0, 0, 0, 0, 0, 0, 1));
        tick_check();
        bus.p1_cor = 8'h22;
        bus.p2_cor = 8'h50;

        // start during PLAY must not restore lives
        start_round();
        blast(8'h22, 8'h00, 1'b0);
        expect_out("play_hit", exp_o(2, 3, 1, 0, 1, 0, 1, 0));
        tick_check();
        bus.explode = '0;
        bus.start   = 1'b1;
        expect_out("start_in_play", exp_o(2, 3, 1, 0, 0, 0, 1, 0));
        tick_check();
        bus.start = 1'b0;

        // Drive p1 into DYING, then reset asynchronously mid-window
        run(44);
        blast(8'h22, 8'h00, 1'b0);
        expect_out("rst_seq_hit2", exp_o(1, 3, 1, 0, 1, 0, 1, 0));
        tick_check();
        bus.explode = '0;
        run(45);
        blast(8'h22, 8'h00, 1'b0);
        expect_out("rst_seq_hit3", exp_o(0, 3, 1, 0, 1, 0, 1, 0));
        tick_check();
        bus.explode = '0;
        run(5);
        reset = 1'b1;
        #1;
        expect_out("async_reset_dying", exp_o(3, 3, 0, 0, 0, 0, 0, 0));
        check_now();
        #2;
        reset = 1'b0;
        expect_out("post_reset_idle", exp_o(3, 3, 0, 0, 0, 0, 0, 0));
        tick_check();
        start_round();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hit_judge.md
# hit_judge

Consumes the per-tile explosion map produced by the bomb stage together with both player coordinates. It decides when a player is caught in a blast, tracks lives and post-hit invulnerability, and runs the round state machine that produces the final game status. It sits directly downstream of the bomb stage. Its outputs drive the player controllers (movement/put enable) and the display/score logic.

## Interface
- LIVES, default 3: lives per player at round start; legal range 1..3.
- INVULN_CYC, default 45: invulnerability cycles after a hit; legal range 1..63.
- DEATH_CYC, default 18: dying-window length in cycles; legal range 1..63.
- clk  in  1  clock (frame-rate tick domain, same as the bomb stage)
- reset  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle pulse; starts a new round
- explode  in  256  tile n is exploding (row-major, tile = row*16+col)
- p1_cor  in  8  player 1 tile index
- p2_cor  in  8  player 2 tile index
- p1_lives  out  2  player 1 remaining lives
- p2_lives  out  2  player 2 remaining lives
- p1_invuln  out  1  player 1 invulnerability counter nonzero
- p2_invuln  out  1  player 2 invulnerability counter nonzero
- p1_hit  out  1  one-cycle pulse, player 1 lost a life
- p2_hit  out  1  one-cycle pulse, player 2 lost a life
- active  out  1  round in progress (PLAY or DYING); gates player input
- game_status  out  2  0 NOT_OVER, 1 GAME_OVER (draw), 2 P1_WIN, 3 P2_WIN

## Operation
- States: IDLE, PLAY, DYING, OVER. All state, lives, counters and outputs are registered.
- IDLE
  - Lives = LIVES, invuln counters = 0, game_status = 0.
  - start -> PLAY.
- PLAY, per player x, each cycle:
  - hit_x = explode[px_cor] && inv_x == 0 && lives_x != 0.
  - On hit_x: lives_x -= 1, inv_x <= INVULN_CYC, px_hit pulses.
  - Else if inv_x != 0: inv_x -= 1.
  - An exploding tile while inv_x != 0 is ignored. It does not reload or extend the counter.
- PLAY exit: when any player's lives become 0 this cycle, go to DYING and load death_ctr <= DEATH_CYC.
  - Both players hit in the same cycle both decrement.
- DYING
  - The hit rule keeps running for the surviving player, so a near-simultaneous kill inside the window becomes a draw.
  - A dead player (lives 0) cannot be hit further.
  - death_ctr decrements each cycle. On the cycle it reads 1, go to OVER and latch game_status:
    - both lives 0 -> 1 (GAME_OVER);
    - only p2 at 0 -> 2 (P1_WIN);
    - only p1 at 0 -> 3 (P2_WIN).
- OVER
  - game_status, lives and hit outputs are frozen; hit pulses are 0; inv counters are cleared.
  - start -> PLAY with lives = LIVES, inv = 0, game_status = 0.
- start in PLAY or DYING is ignored.
- Arithmetic:
  - lives are 2-bit and never decrement below 0.
  - Counters are 6-bit and never wrap below 0.
  - Coordinates are used as 8-bit indices with no range checks (all 256 values valid).
- p1_cor == p2_cor on an exploding tile: both players are hit.

## Timing
- Reset values: state IDLE, p1_lives = p2_lives = LIVES, invuln counters 0, p1_invuln = p2_invuln = 0, p1_hit = p2_hit = 0, active = 0, game_status = 0.
- Hit latency: explode/coordinate condition true at edge k means lives, hit pulse and px_invuln change after edge k (visible in cycle k+1).
  - The pulse is exactly 1 cycle wide.
- Invulnerability:
  - p_invuln stays high for INVULN_CYC cycles after the hit.
  - A new hit is possible on the first sample with the counter at 0, i.e. INVULN_CYC+1 cycles after the previous hit.
- Dying window: the final hit sets lives = 0 at edge k. Then:
  - game_status becomes valid and active drops at edge k+DEATH_CYC;
  - hits in the window are sampled at edges k+1 .. k+DEATH_CYC-1.
- start: start high at edge k means active = 1 and lives = LIVES from edge k.
- Asynchronous reset at any point, including mid-DYING, returns immediately to the reset values.

## Test plan
- Reset, then start; explode[p1_cor = 0x22] high for 1 cycle -> next cycle p1_lives = 2, p1_hit = 1 for 1 cycle, p1_invuln = 1 for 45 cycles; p2_lives stays 3.
- Hold explode[p1_cor] high continuously for 100 cycles from full lives -> hits at cycles 0, 46, 92; p1_lives = 0 after the third hit; DYING entered.
- p1 at 0 lives, no p2 hits -> 18 cycles later game_status = 3, active = 0; further explode on p2 has no effect.
- p1 dies, then p2's last life is hit 10 cycles later -> game_status = 1 (draw). Repeat with the p2 hit 18 cycles later -> game_status = 3.
- p1_cor == p2_cor = 0x80, both with 1 life, explode[0x80] pulse -> both hit pulses in the same cycle, game_status = 1 after 18 cycles.
- Assert reset mid-DYING -> all outputs return to reset values immediately. start in OVER -> lives 3/3, status 0, active 1 next cycle. start during PLAY -> no change.
